cond_ctrl_fsm: RTL and testbench
================================

Name: cond_ctrl_fsm

Overview:
- Parametrised multi-cycle successor to the single-cycle control decoder.
- Accepts decoded instruction fields through a valid/ready handshake and evaluates the full ARM-style condition field against an architectural flag register that this block owns.
- Sequences EXEC, MEM and WB phases and drives datapath selects, ALU control, memory request and register/PC write strobes.
- Sits between the instruction fetch/decode stage and the ALU/register-file/memory datapath.

Parameters:
- ALU_CTRL_W, 3, width of alu_ctrl; must be >= 3.
- MEM_TIMEOUT, 16, maximum cycles in MEM waiting for mem_ack before aborting; must be >= 2.
- CNT_W, 5, width of the MEM wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- instr_valid  in  1  decoded instruction fields are valid.
- instr_ready  out  1  block can accept an instruction.
- cond  in  4  condition field.
- op  in  2  0 data-processing, 1 memory, 2 branch, 3 undefined.
- funct  in  6  [5] immediate, [4:1] opcode, [0] S bit (load bit for op=1).
- sh  in  2  shift type.
- alu_flags  in  4  {V,C,N,Z} from ALU, valid during EXEC.
- mem_ack  in  1  memory completion.
- flags  out  4  architectural flag register {V,C,N,Z}.
- alu_ctrl  out  ALU_CTRL_W  0 ADD, 1 SUB, 2 MUL, 3 OR, 4 LSL, 5 LSR, 6 ASR, 7 ROR.
- sel_b  out  1  immediate operand select.
- sel_dira  out  1  alternate A-address select (MUL).
- sel_dest  out  1  alternate destination select.
- imm_src  out  2  0 data-processing, 1 memory, 2 branch extension.
- reg_wr  out  1  register-file write strobe (WB only).
- pc_wr  out  1  branch-taken PC load strobe.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  store qualifier with mem_req.
- illegal  out  1  one-cycle pulse on undefined op/funct.
- timeout  out  1  one-cycle pulse on MEM abort.

Behaviour:
- States: IDLE, EXEC, MEM, WB. All outputs are registered. Reset sets state to IDLE and all outputs and flags to 0.
- instr_ready = 1 only in IDLE. A handshake (valid & ready) latches cond/op/funct/sh and moves to EXEC.
- Condition evaluation uses the flags value registered at handshake:
  - 0 EQ Z; 1 NE !Z; 2 CS C; 3 CC !C; 4 MI N; 5 PL !N; 6 VS V; 7 VC !V.
  - 8 HI C&!Z; 9 LS !C|Z; 10 GE N==V; 11 LT N!=V; 12 GT !Z&(N==V); 13 LE Z|(N!=V).
  - 14 AL true; 15 NV false.
- EXEC, condition false: all strobes stay 0, flags unchanged, next state IDLE.
- EXEC, op=0 (data-processing), funct[4:1] decode:
  - 0 MUL: sel_dira=1, sel_dest=1.
  - 2 SUB, 4 ADD, 12 OR.
  - 13 shift: LSL/LSR from sh.
  - Flags are loaded from alu_flags at the end of EXEC when funct[0]=1. Next state WB.
  - Undefined funct: illegal pulse, next state IDLE, no writes.
- EXEC, op=1 (memory): alu_ctrl=ADD, imm_src=1, sel_dest=1. mem_req asserts on entry to MEM; mem_we = !funct[0].
- MEM: counter increments each cycle.
  - mem_ack: drop mem_req; load goes to WB, store goes to IDLE.
  - Counter reaches MEM_TIMEOUT without ack: timeout pulse, drop mem_req, go to IDLE, no writeback.
  - mem_ack on the timeout cycle counts as ack.
- EXEC, op=2 (branch): sel_b=1, imm_src=2, one-cycle pc_wr pulse, next state IDLE.
- op=3: illegal pulse, next state IDLE.
- WB: one-cycle reg_wr pulse, then IDLE.
- Latency: handshake at cycle 0; EXEC at 1; WB at 2; instr_ready again at 3.
- Asynchronous reset mid-operation aborts the instruction: mem_req drops immediately and no strobe is emitted.

Optional Feature:
- SHIFT_EXT_EN defined: sh=2 decodes ASR (alu_ctrl=6); sh=3 decodes ROR (alu_ctrl=7).
- SHIFT_EXT_EN undefined: sh=2/3 on opcode 13 is undefined funct (illegal pulse, no writes).

Decomposition:
- Package ctrl_pkg holds: op codes, cond codes, ALU control codes, state enum, flag bit indices.
- One natural sub-module, cond_eval: combinational mapping of (cond, flags) to pass.

Test Plan:
- Reset, then ADD with S=1 (op=0, funct=6'b001001, cond=14), alu_flags=4'b0001 -> reg_wr at cycle 2, flags=4'b0001 at cycle 2, instr_ready at cycle 3.
- flags Z=1, then NE instruction (cond=1) -> no reg_wr, flags unchanged; EQ instruction (cond=0) -> reg_wr.
- Load (op=1, funct[0]=1), mem_ack after 3 MEM cycles -> mem_req high for 3 cycles, mem_we=0, then reg_wr pulse.
- Store with mem_ack never asserted -> timeout pulse after 16 MEM cycles, mem_req low, no reg_wr, back to IDLE.
- Branch cond=13 with N=1, V=0 -> pc_wr pulse; same with N=V=0, Z=0 -> no pc_wr.
- op=3, and shift with sh=2 built without SHIFT_EXT_EN -> illegal pulse, no strobes; rst_n low during MEM -> mem_req 0 immediately.

Source files
------------

// File: rtl/cond_ctrl_fsm_pkg.sv
// ctrl_pkg: shared codes, decode struct and state enum for cond_ctrl_fsm.
package ctrl_pkg;
    localparam logic [1:0] OP_DP  = 2'd0;
    localparam logic [1:0] OP_MEM = 2'd1;
    localparam logic [1:0] OP_BR  = 2'd2;
    localparam logic [1:0] OP_UND = 2'd3;

    localparam logic [3:0] C_EQ = 4'd0,  C_NE = 4'd1,  C_CS = 4'd2,  C_CC = 4'd3;
    localparam logic [3:0] C_MI = 4'd4,  C_PL = 4'd5,  C_VS = 4'd6,  C_VC = 4'd7;
    localparam logic [3:0] C_HI = 4'd8,  C_LS = 4'd9,  C_GE = 4'd10, C_LT = 4'd11;
    localparam logic [3:0] C_GT = 4'd12, C_LE = 4'd13, C_AL = 4'd14, C_NV = 4'd15;

    localparam logic [2:0] ALU_ADD = 3'd0, ALU_SUB = 3'd1, ALU_MUL = 3'd2, ALU_OR  = 3'd3;
    localparam logic [2:0] ALU_LSL = 3'd4, ALU_LSR = 3'd5, ALU_ASR = 3'd6, ALU_ROR = 3'd7;

    localparam logic [3:0] FN_MUL = 4'd0, FN_SUB = 4'd2, FN_ADD = 4'd4, FN_OR = 4'd12, FN_SHIFT = 4'd13;

    localparam int FLAG_Z = 0;
    localparam int FLAG_N = 1;
    localparam int FLAG_C = 2;
    localparam int FLAG_V = 3;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MEM, S_WB} state_t;

    typedef struct packed {
        logic [2:0] alu;
        logic       sel_b;
        logic       sel_dira;
        logic       sel_dest;
        logic [1:0] imm_src;
        logic       undef;
    } dec_t;
endpackage

// File: rtl/cond_ctrl_fsm_if.sv
// cond_ctrl_fsm_if: decode-stage handshake plus datapath control/status bundle.
interface cond_ctrl_fsm_if
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W = 3
);
    logic                  instr_valid;
    logic                  instr_ready;
    logic [3:0]            cond;
    logic [1:0]            op;
    logic [5:0]            funct;
    logic [1:0]            sh;
    logic [3:0]            alu_flags;
    logic                  mem_ack;
    logic [3:0]            flags;
    logic [ALU_CTRL_W-1:0] alu_ctrl;
    logic                  sel_b;
    logic                  sel_dira;
    logic                  sel_dest;
    logic [1:0]            imm_src;
    logic                  reg_wr;
    logic                  pc_wr;
    logic                  mem_req;
    logic                  mem_we;
    logic                  illegal;
    logic                  timeout;

    modport master (
        output instr_valid, cond, op, funct, sh, alu_flags, mem_ack,
        input  instr_ready, flags, alu_ctrl, sel_b, sel_dira, sel_dest, imm_src,
               reg_wr, pc_wr, mem_req, mem_we, illegal, timeout
    );

    modport slave (
        input  instr_valid, cond, op, funct, sh, alu_flags, mem_ack,
        output instr_ready, flags, alu_ctrl, sel_b, sel_dira, sel_dest, imm_src,
               reg_wr, pc_wr, mem_req, mem_we, illegal, timeout
    );
endinterface

// File: rtl/cond_ctrl_fsm_cond_eval.sv
// cond_eval: ARM-style condition field evaluation against {V,C,N,Z}.
module cond_eval
    import ctrl_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] flags_i,
    output logic       pass_o
);
    logic z, n, c, v, base;

    assign z = flags_i[FLAG_Z];
    assign n = flags_i[FLAG_N];
    assign c = flags_i[FLAG_C];
    assign v = flags_i[FLAG_V];

    // even codes test a predicate, odd codes its complement; pair 7 gives AL (14) / NV (15)
    always_comb begin
        base = 1'b1;
        case (cond_i[3:1])
            3'd0:    base = z;
            3'd1:    base = c;
            3'd2:    base = n;
            3'd3:    base = v;
            3'd4:    base = c & ~z;
            3'd5:    base = n ~^ v;
            3'd6:    base = ~z & (n ~^ v);
            default: base = 1'b1;
        endcase
        pass_o = base ^ cond_i[0];
    end
endmodule

// File: rtl/cond_ctrl_fsm.sv
// cond_ctrl_fsm: multi-cycle IDLE/EXEC/MEM/WB control FSM with condition evaluation and owned flags.
// Define SHIFT_EXT_EN to decode ASR/ROR (sh=2/3); otherwise those shifts are undefined.
module cond_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int ALU_CTRL_W  = 3,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input logic            clk,
    input logic            rst_n,
    cond_ctrl_fsm_if.slave bus
);
    state_t           state_q, state_d;
    dec_t             dec, dec_q, dec_d;
    logic [3:0]       cond_q, cond_d, flags_q, flags_d;
    logic [1:0]       op_q, op_d;
    logic             s_q, s_d, pass;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rdy_q, rdy_d, reg_wr_q, reg_wr_d, pc_wr_q, pc_wr_d;
    logic             mem_req_q, mem_req_d, mem_we_q, mem_we_d;
    logic             illegal_q, illegal_d, timeout_q, timeout_d;

    cond_eval u_cond_eval (.cond_i(cond_q), .flags_i(flags_q), .pass_o(pass));

    // decode incoming fields; captured at handshake so selects are stable from EXEC onward
    always_comb begin
        dec = '0;
        case (bus.op)
            OP_DP: begin
                dec.sel_b = bus.funct[5];
                case (bus.funct[4:1])
                    FN_MUL: begin
                        dec.alu      = ALU_MUL;
                        dec.sel_dira = 1'b1;
                        dec.sel_dest = 1'b1;
                    end
                    FN_SUB:   dec.alu = ALU_SUB;
                    FN_ADD:   dec.alu = ALU_ADD;
                    FN_OR:    dec.alu = ALU_OR;
`ifdef SHIFT_EXT_EN
                    FN_SHIFT: dec.alu = {1'b1, bus.sh};
`else
                    FN_SHIFT: begin
                        dec.alu   = {1'b1, bus.sh};
                        dec.undef = bus.sh[1];
                    end
`endif
                    default:  dec.undef = 1'b1;
                endcase
            end
            OP_MEM: begin
                dec.alu      = ALU_ADD;
                dec.imm_src  = 2'd1;
                dec.sel_dest = 1'b1;
            end
            OP_BR: begin
                dec.sel_b   = 1'b1;
                dec.imm_src = 2'd2;
            end
            default: dec.undef = 1'b1;
        endcase
        if (dec.undef) begin
            dec       = '0;
            dec.undef = 1'b1;
        end
    end

    // next state and next registered outputs; strobes are derived from the state being entered
    always_comb begin
        state_d   = state_q;
        dec_d     = dec_q;
        cond_d    = cond_q;
        op_d      = op_q;
        s_d       = s_q;
        flags_d   = flags_q;
        cnt_d     = cnt_q;
        pc_wr_d   = 1'b0;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.instr_valid && rdy_q) begin
                    state_d = S_EXEC;
                    dec_d   = dec;
                    cond_d  = bus.cond;
                    op_d    = bus.op;
                    s_d     = bus.funct[0];
                end
            end
            S_EXEC: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                if (pass && dec_q.undef) begin
                    illegal_d = 1'b1;
                end else if (pass) begin
                    case (op_q)
                        OP_DP: begin
                            state_d = S_WB;
                            flags_d = s_q ? bus.alu_flags : flags_q;
                        end
                        OP_MEM:  state_d = S_MEM;
                        default: pc_wr_d = 1'b1;
                    endcase
                end
            end
            S_MEM: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.mem_ack) begin
                    state_d = s_q ? S_WB : S_IDLE;
                end else if (cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
                    state_d   = S_IDLE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        rdy_d     = state_d == S_IDLE;
        reg_wr_d  = state_d == S_WB;
        mem_req_d = state_d == S_MEM;
        mem_we_d  = mem_req_d && !s_q;
    end

    // state and output registers; async reset aborts any instruction in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            dec_q     <= '0;
            cond_q    <= '0;
            op_q      <= '0;
            s_q       <= 1'b0;
            flags_q   <= '0;
            cnt_q     <= '0;
            rdy_q     <= 1'b0;
            reg_wr_q  <= 1'b0;
            pc_wr_q   <= 1'b0;
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dec_q     <= dec_d;
            cond_q    <= cond_d;
            op_q      <= op_d;
            s_q       <= s_d;
            flags_q   <= flags_d;
            cnt_q     <= cnt_d;
            rdy_q     <= rdy_d;
            reg_wr_q  <= reg_wr_d;
            pc_wr_q   <= pc_wr_d;
            mem_req_q <= mem_req_d;
            mem_we_q  <= mem_we_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

    assign bus.instr_ready = rdy_q;
    assign bus.flags       = flags_q;
    assign bus.alu_ctrl    = ALU_CTRL_W'(dec_q.alu);
    assign bus.sel_b       = dec_q.sel_b;
    assign bus.sel_dira    = dec_q.sel_dira;
    assign bus.sel_dest    = dec_q.sel_dest;
    assign bus.imm_src     = dec_q.imm_src;
    assign bus.reg_wr      = reg_wr_q;
    assign bus.pc_wr       = pc_wr_q;
    assign bus.mem_req     = mem_req_q;
    assign bus.mem_we      = mem_we_q;
    assign bus.illegal     = illegal_q;
    assign bus.timeout     = timeout_q;
endmodule

// File: tb/tb_cond_ctrl_fsm.sv
// tb_cond_ctrl_fsm: directed plus randomized checks of cond_ctrl_fsm against a transaction-level model.
`timescale 1ns/1ps
module tb_cond_ctrl_fsm;
    localparam int TO = 16;
`ifdef SHIFT_EXT_EN
    localparam bit EXT = 1'b1;
`else
    localparam bit EXT = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int n_checks = 0;
    int n_errors = 0;
    logic [3:0] fl_m = 4'd0;

    always #5 clk = ~clk;

    cond_ctrl_fsm_if #(.ALU_CTRL_W(3)) bus ();
    cond_ctrl_fsm #(.ALU_CTRL_W(3), .MEM_TIMEOUT(TO), .CNT_W(5)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // condition table written out per mnemonic; flags are {V,C,N,Z}
    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit z, n, cf, v;
        z = f[0]; n = f[1]; cf = f[2]; v = f[3];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cf;
            4'd3:  return !cf;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cf && !z;
            4'd9:  return !cf || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    // expected alu_ctrl, or -1 when the instruction is undefined
    function automatic int exp_alu(input logic [1:0] op, input logic [3:0] opc, input logic [1:0] sh);
        if (op == 2'd3) return -1;
        if (op != 2'd0) return 0;
        case (opc)
            4'd0:  return 2;
            4'd2:  return 1;
            4'd4:  return 0;
            4'd12: return 3;
            4'd13: return (sh < 2'd2 || EXT) ? 4 + int'(sh) : -1;
            default: return -1;
        endcase
    endfunction

    function automatic int outs_packed();
        return int'({bus.instr_ready, bus.flags, bus.alu_ctrl, bus.sel_b, bus.sel_dira, bus.sel_dest,
                     bus.imm_src, bus.reg_wr, bus.pc_wr, bus.mem_req, bus.mem_we, bus.illegal, bus.timeout});
    endfunction

    // one instruction: ack_at = MEM cycle (1-based) in which mem_ack is raised; outside 1..TO means never
    task automatic run(input logic [3:0] c, input logic [1:0] op, input logic [5:0] fn,
                       input logic [1:0] sh, input logic [3:0] af, input int ack_at);
        int alu, e_sel, rdy_at, wr_at, n_wr, n_pc, n_ill, n_to, n_req, n_we;
        int e_rdy, e_wr, e_pc, e_ill, e_to, e_req, e_we;
        bit pass;
        pass  = cond_pass(c, fl_m);
        alu   = exp_alu(op, fn[4:1], sh);
        e_sel = 0;
        if (alu >= 0) begin
            if (op == 2'd0) e_sel = {fn[5], fn[4:1] == 4'd0, fn[4:1] == 4'd0, 2'd0};
            if (op == 2'd1) e_sel = {1'b0, 1'b0, 1'b1, 2'd1};
            if (op == 2'd2) e_sel = {1'b1, 1'b0, 1'b0, 2'd2};
        end
        e_rdy = 2; e_wr = -1; e_pc = 0; e_ill = 0; e_to = 0; e_req = 0; e_we = 0;
        if (pass && alu < 0) e_ill = 1;
        else if (pass && op == 2'd0) begin
            e_wr = 2; e_rdy = 3;
            if (fn[0]) fl_m = af;
        end else if (pass && op == 2'd2) e_pc = 1;
        else if (pass && op == 2'd1) begin
            if (ack_at >= 1 && ack_at <= TO) e_req = ack_at;
            else begin e_req = TO; e_to = 1; end
            e_we = fn[0] ? 0 : e_req;
            if (fn[0] && !e_to) begin e_wr = e_req + 2; e_rdy = e_req + 3; end
            else e_rdy = e_req + 2;
        end
        for (int i = 0; i < 40 && bus.instr_ready !== 1'b1; i++) @(negedge clk);
        check("ready_pre", int'(bus.instr_ready), 1);
        bus.cond = c; bus.op = op; bus.funct = fn; bus.sh = sh; bus.alu_flags = af;
        bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        rdy_at = -1; wr_at = -1; n_wr = 0; n_pc = 0; n_ill = 0; n_to = 0; n_req = 0; n_we = 0;
        for (int k = 1; k <= 40 && rdy_at < 0; k++) begin
            @(negedge clk);
            if (k == 1) begin
                check("alu_ctrl", int'(bus.alu_ctrl), alu < 0 ? 0 : alu);
                check("selects", int'({bus.sel_b, bus.sel_dira, bus.sel_dest, bus.imm_src}), e_sel);
            end
            if (bus.reg_wr) begin
                n_wr++;
                if (wr_at < 0) wr_at = k;
            end
            n_pc += int'(bus.pc_wr);
            n_ill += int'(bus.illegal);
            n_to += int'(bus.timeout);
            if (bus.mem_req) begin
                n_req++;
                n_we += int'(bus.mem_we);
            end
            bus.mem_ack = bus.mem_req && n_req == ack_at;
            if (bus.instr_ready) rdy_at = k;
        end
        bus.mem_ack = 1'b0;
        check("ready_cycle", rdy_at, e_rdy);
        check("reg_wr_cycle", wr_at, e_wr);
        check("reg_wr_count", n_wr, e_wr >= 0 ? 1 : 0);
        check("pc_wr_count", n_pc, e_pc);
        check("illegal_count", n_ill, e_ill);
        check("timeout_count", n_to, e_to);
        check("mem_req_cycles", n_req, e_req);
        check("mem_we_cycles", n_we, e_we);
        check("flags", int'(bus.flags), int'(fl_m));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [3:0] opc_pool [6];
        logic [3:0] opc;
        bus.instr_valid = 1'b0; bus.cond = '0; bus.op = '0; bus.funct = '0;
        bus.sh = '0; bus.alu_flags = '0; bus.mem_ack = 1'b0;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset_outs", outs_packed(), 0);
        @(negedge clk);
        check("reset_outs_held", outs_packed(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_reset", int'(bus.instr_ready), 1);

        run(4'd14, 2'd0, 6'b001001, 2'd0, 4'b0001, 0);
        run(4'd1,  2'd0, 6'b001000, 2'd0, 4'b0000, 0);
        run(4'd0,  2'd0, 6'b001000, 2'd0, 4'b0000, 0);
        run(4'd14, 2'd1, 6'b000001, 2'd0, 4'b0000, 3);
        run(4'd14, 2'd1, 6'b000000, 2'd0, 4'b0000, 0);
        run(4'd14, 2'd1, 6'b000001, 2'd0, 4'b0000, TO);
        run(4'd14, 2'd1, 6'b000000, 2'd0, 4'b0000, 1);
        run(4'd14, 2'd0, 6'b001001, 2'd0, 4'b0010, 0);
        run(4'd13, 2'd2, 6'b000000, 2'd0, 4'b0000, 0);
        run(4'd14, 2'd0, 6'b001001, 2'd0, 4'b0000, 0);
        run(4'd13, 2'd2, 6'b000000, 2'd0, 4'b0000, 0);
        run(4'd14, 2'd3, 6'b001001, 2'd0, 4'b1111, 0);
        run(4'd14, 2'd0, 6'b011011, 2'd2, 4'b1010, 0);
        run(4'd14, 2'd0, 6'b011011, 2'd3, 4'b0110, 0);
        run(4'd14, 2'd0, 6'b111010, 2'd1, 4'b0000, 0);
        run(4'd14, 2'd0, 6'b100001, 2'd0, 4'b1100, 0);
        run(4'd15, 2'd2, 6'b000000, 2'd0, 4'b0000, 0);

        bus.cond = 4'd14; bus.op = 2'd1; bus.funct = 6'b000000; bus.instr_valid = 1'b1;
        @(posedge clk);
        #1 bus.instr_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mem_req_before_rst", int'(bus.mem_req), 1);
        #2 rst_n = 1'b0;
        #1;
        check("mem_req_async_rst", int'(bus.mem_req), 0);
        check("flags_async_rst", int'(bus.flags), 0);
        fl_m = 4'd0;
        @(negedge clk);
        check("outs_in_rst", outs_packed(), 0);
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst2", int'(bus.instr_ready), 1);

        opc_pool[0] = 4'd0; opc_pool[1] = 4'd2; opc_pool[2] = 4'd4;
        opc_pool[3] = 4'd12; opc_pool[4] = 4'd13; opc_pool[5] = 4'd0;
        for (int i = 0; i < 80; i++) begin
            opc = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(0, 15)) : opc_pool[$urandom_range(0, 4)];
            run(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                {1'($urandom_range(0, 1)), opc, 1'($urandom_range(0, 1))},
                2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), int'($urandom_range(0, 18)));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
